// File: rtl/seg7_reader.sv
`default_nettype none
// ============================================================================
// Module   : seg7_reader
// Purpose  : Collects NDIGITS active-low seven-segment patterns into a BCD
//            frame, flags invalid patterns, and holds each complete frame
//            behind a valid/ready handshake.
// Options  : define SEG7_READER_BLANK_EN to decode 0x7F (all segments off)
//            as a valid blank digit (nibble 4'hF).
// Revision : 1.0  initial release
// ============================================================================
module seg7_reader #(
  parameter int NDIGITS = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             seg,
  input  logic                   seg_valid,
  input  logic                   seg_first,
  output logic                   in_ready,
  output logic [4*NDIGITS-1:0]   bcd,
  output logic                   frame_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             err_count
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);
  localparam logic [CW-1:0] C_LAST = CW'(NDIGITS);

  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_HOLD    = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  shift_q, shift_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    err_count_q, err_count_d;

  logic [3:0]    nibble;
  logic          nib_bad;
  logic          accept;
  logic          restart;
  logic          frame_done;
  logic [W-1:0]  shifted;
  logic [W-1:0]  next_shift;
  logic [CW-1:0] next_cnt;
  logic          next_ferr;

  // Pattern decode: known digits map to BCD, everything else is an error nibble
  always_comb begin
    nibble  = 4'hE;
    nib_bad = 1'b1;
    case (seg)
      7'h40: begin nibble = 4'd0; nib_bad = 1'b0; end
      7'h79: begin nibble = 4'd1; nib_bad = 1'b0; end
      7'h24: begin nibble = 4'd2; nib_bad = 1'b0; end
      7'h30: begin nibble = 4'd3; nib_bad = 1'b0; end
      7'h19: begin nibble = 4'd4; nib_bad = 1'b0; end
      7'h12: begin nibble = 4'd5; nib_bad = 1'b0; end
      7'h02: begin nibble = 4'd6; nib_bad = 1'b0; end
      7'h78: begin nibble = 4'd7; nib_bad = 1'b0; end
      7'h00: begin nibble = 4'd8; nib_bad = 1'b0; end
      7'h10: begin nibble = 4'd9; nib_bad = 1'b0; end
`ifdef SEG7_READER_BLANK_EN
      7'h7F: begin nibble = 4'hF; nib_bad = 1'b0; end
`else
      7'h7F: begin nibble = 4'hE; nib_bad = 1'b1; end
`endif
      default: begin nibble = 4'hE; nib_bad = 1'b1; end
    endcase
  end

  // A single-digit frame has no older nibbles to carry along
  generate
    if (NDIGITS == 1) begin : g_single
      assign shifted = nibble;
    end else begin : g_multi
      assign shifted = {shift_q[W-5:0], nibble};
    end
  endgenerate

  // Digit acceptance and frame-assembly arithmetic
  always_comb begin
    accept     = seg_valid && in_ready;
    // An empty counter means no frame in progress, so the digit starts one
    restart    = seg_first || (cnt_q == '0);
    next_shift = restart ? W'(nibble) : shifted;
    next_cnt   = restart ? CW'(1) : (cnt_q + CW'(1));
    next_ferr  = restart ? nib_bad : (ferr_q | nib_bad);
    frame_done = accept && (next_cnt == C_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fill a frame, then hold it until the consumer takes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (frame_done) state_d = S_HOLD;
      S_HOLD:    if (out_ready)  state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  // Output decode of the state; in_ready is forced low while reset is asserted
  always_comb begin
    in_ready  = (state_q == S_COLLECT) && !reset;
    out_valid = (state_q == S_HOLD);
  end

  // Datapath next values: shift register, digit counter, frame and error tallies
  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    ferr_d      = ferr_q;
    err_count_d = err_count_q;
    if (accept) begin
      shift_d = next_shift;
      cnt_d   = next_cnt;
      ferr_d  = next_ferr;
      if (nib_bad && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
    // Handshake empties the counter; the held image stays until a new digit
    if (out_valid && out_ready) begin
      cnt_d = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      ferr_q      <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      ferr_q      <= ferr_d;
      err_count_q <= err_count_d;
    end
  end

  // The shift register itself is the frame image; it is frozen in HOLD
  always_comb begin
    bcd       = shift_q;
    frame_err = ferr_q;
    err_count = err_count_q;
  end

endmodule
`default_nettype wire
